// File: rtl/arbiter.sv
// Four-requester round-robin arbiter with registered one-hot, non-preemptive grants.
// Define ARBITER_MAX_HOLD_EN to cap a holder at MAX_HOLD consecutive cycles when others wait.
module arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req3,
  input  logic req2,
  input  logic req1,
  input  logic req0,
  output logic gnt3,
  output logic gnt2,
  output logic gnt1,
  output logic gnt0
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arbiter: MAX_HOLD must be in 1..255");
  end

  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] last;
  logic [3:0] mask;
  logic       hold;
  logic       hold_raw;
  logic       found;
  logic [1:0] nxt_idx;
  logic [1:0] idx;

  assign req      = {req3, req2, req1, req0};
  assign hold_raw = |(gnt & req);

`ifdef ARBITER_MAX_HOLD_EN
  logic [7:0] cnt;
  logic       force_rearb;

  // A holder at its limit is pushed out only if someone else is waiting.
  assign force_rearb = hold_raw && (cnt >= 8'(MAX_HOLD)) && (|(req & ~gnt));
  assign hold        = hold_raw && !force_rearb;
  assign mask        = force_rearb ? (req & ~gnt) : req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (hold) begin
      if (cnt < 8'(MAX_HOLD)) cnt <= cnt + 8'd1;
    end else if (found) begin
      cnt <= 8'd1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign hold = hold_raw;
  assign mask = req;
`endif

  // Scan starts one past the last grant so priority rotates.
  always_comb begin
    found   = 1'b0;
    nxt_idx = last;
    idx     = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && mask[idx]) begin
        found   = 1'b1;
        nxt_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt  <= '0;
      last <= 2'd3;
    end else if (hold) begin
      gnt  <= gnt;
    end else if (found) begin
      gnt  <= 4'b0001 << nxt_idx;
      last <= nxt_idx;
    end else begin
      gnt  <= '0;
    end
  end

  assign {gnt3, gnt2, gnt1, gnt0} = gnt;

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter: directed scenarios plus random traffic against a
// priority-list reference model; honours ARBITER_MAX_HOLD_EN with MAX_HOLD = 4.
module tb_arbiter;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req3 = 1'b0, req2 = 1'b0, req1 = 1'b0, req0 = 1'b0;
  logic gnt3, gnt2, gnt1, gnt0;

  int checks = 0;
  int errors = 0;

  // Reference: granted index (-1 = none), last granted index, consecutive hold cycles.
  int m_gnt  = -1;
  int m_last = 3;
  int m_cnt  = 0;

  arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .req3(req3),
    .req2(req2),
    .req1(req1),
    .req0(req0),
    .gnt3(gnt3),
    .gnt2(gnt2),
    .gnt1(gnt1),
    .gnt0(gnt0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_vec();
    return (m_gnt < 0) ? 4'b0000 : (4'b0001 << m_gnt);
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic rs);
    bit keep;
    int excl;
    if (!rs) begin
      m_gnt = -1; m_last = 3; m_cnt = 0;
      return;
    end
    keep = (m_gnt >= 0) && r[m_gnt];
    excl = -1;
`ifdef ARBITER_MAX_HOLD_EN
    if (keep && m_cnt >= MH && ((r & ~(4'b0001 << m_gnt)) != 4'b0000)) begin
      keep = 0;
      excl = m_gnt;
    end
`endif
    if (keep) begin
      if (m_cnt < MH) m_cnt++;
      return;
    end
    m_gnt = -1;
    m_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last + k) % 4;
      if (r[i] && i != excl) begin
        m_gnt = i; m_last = i; m_cnt = 1;
        break;
      end
    end
  endfunction

  logic [3:0] gv;

  // Drive, clock, update model on the same edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic rs = 1'b1);
    {req3, req2, req1, req0} = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    gv = {gnt3, gnt2, gnt1, gnt0};
    chk("model", 8'(gv), 8'(model_vec()));
    chk("onehot", 8'($countones(gv) <= 1), 8'd1);
    chk("gnt_without_req", 8'(gv & ~r), 8'd0);
  endtask

  initial begin
    int ord;
    int held;
    int prev;
    logic [3:0] r;

    // Reset priority
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("reset_clear", 8'(gv), 8'h0);
    step(4'b0001);
    chk("reset_prio_gnt0", 8'(gv), 8'h1);
    step(4'b0000);
    chk("release_gnt0", 8'(gv), 8'h0);

    // Rotation after release (last = 0 here)
    step(4'b0011); chk("rot_gnt1", 8'(gv), 8'h2);
    step(4'b0101); chk("rot_gnt2", 8'(gv), 8'h4);
    step(4'b1001); chk("rot_gnt3", 8'(gv), 8'h8);
    step(4'b0001); chk("rot_gnt0", 8'(gv), 8'h1);
    step(4'b0000); chk("rot_idle", 8'(gv), 8'h0);

    // Fairness: each holder drops for one cycle after two granted cycles
    step(4'b0000, 1'b0);
    ord = 0; held = 0; prev = -1;
    for (int c = 0; c < 40; c++) begin
      r = 4'b1111;
      if (m_gnt >= 0 && held >= 2) r[m_gnt] = 1'b0;
      step(r);
      if (m_gnt >= 0 && m_gnt != prev) begin
        chk("fair_order", 8'(gv), 8'(4'b0001 << (ord % 4)));
        ord++;
        held = 1;
      end else if (m_gnt >= 0) begin
        held++;
      end
      prev = m_gnt;
    end
    chk("fair_count", 8'(ord >= 12), 8'd1);

    // Reset mid-grant
    step(4'b0000, 1'b0);
    step(4'b0100); chk("mid_gnt2", 8'(gv), 8'h4);
    step(4'b0110, 1'b0); chk("mid_reset_clear", 8'(gv), 8'h0);
    step(4'b0110); chk("mid_after_reset_gnt1", 8'(gv), 8'h2);

`ifdef ARBITER_MAX_HOLD_EN
    // Hold limit: alternating blocks of MH cycles, then a lone holder keeps it
    step(4'b0000, 1'b0);
    for (int t = 0; t < 4 * MH; t++) begin
      step(4'b0011);
      chk("hold_alternate", 8'(gv), 8'(((t / MH) % 2) ? 4'b0010 : 4'b0001));
    end
    step(4'b0000, 1'b0);
    for (int t = 0; t < 3 * MH; t++) begin
      step(4'b0001);
      chk("hold_alone", 8'(gv), 8'h1);
    end
`endif

    // Random traffic with occasional resets
    step(4'b0000, 1'b0);
    for (int c = 0; c < 10000; c++) begin
      step(4'($urandom), ($urandom_range(0, 199) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
